// File: rtl/piso_serializer.sv
// Parallel-in/serial-out converter: takes a word over valid/ready and shifts it
// out one bit per BIT_CYCLES clocks, with strobe/first/last framing flags.
module piso_serializer #(
  parameter int WORD_WIDTH = 8,
  parameter int BIT_CYCLES = 1,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WORD_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  ser_out,
  output logic                  ser_valid,
  output logic                  ser_strobe,
  output logic                  ser_first,
  output logic                  ser_last,
  output logic                  busy
);

  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int BW = $clog2(WORD_WIDTH);
  localparam logic [CW-1:0] CYC_MAX = CW'(BIT_CYCLES - 1);
  localparam logic [BW-1:0] BIT_MAX = BW'(WORD_WIDTH - 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t state_reg, state_next;

  logic [WORD_WIDTH-1:0] shift_q;
  logic [WORD_WIDTH-1:0] shift_adv;
  logic [CW-1:0]         cyc_cnt;
  logic [BW-1:0]         bit_cnt;

  logic cyc_end;
  logic bit_end;
  logic word_end;
  logic accept;

  assign cyc_end  = (cyc_cnt == CYC_MAX);
  assign bit_end  = (bit_cnt == BIT_MAX);
  assign word_end = (state_reg == SHIFT) && cyc_end && bit_end;
  assign accept   = in_valid && in_ready;

  // Zero fill means the register is all-zero once a word has fully drained,
  // which is what keeps ser_out low in IDLE.
  generate
    if (MSB_FIRST) begin : g_msb
      assign shift_adv = {shift_q[WORD_WIDTH-2:0], 1'b0};
      assign ser_out   = shift_q[WORD_WIDTH-1];
    end else begin : g_lsb
      assign shift_adv = {1'b0, shift_q[WORD_WIDTH-1:1]};
      assign ser_out   = shift_q[0];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) state_next = SHIFT;
      end
      SHIFT: begin
        if (word_end && !accept) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready   = 1'b0;
    ser_valid  = 1'b0;
    ser_strobe = 1'b0;
    ser_first  = 1'b0;
    ser_last   = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
      end
      SHIFT: begin
        in_ready   = cyc_end && bit_end;
        ser_valid  = 1'b1;
        ser_strobe = (cyc_cnt == '0);
        ser_first  = (bit_cnt == '0);
        ser_last   = bit_end;
      end
      default: ;
    endcase
  end

  assign busy = ser_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q <= '0;
      cyc_cnt <= '0;
      bit_cnt <= '0;
    end else if (accept) begin
      shift_q <= in_data;
      cyc_cnt <= '0;
      bit_cnt <= '0;
    end else if (state_reg == SHIFT) begin
      if (cyc_end) begin
        cyc_cnt <= '0;
        shift_q <= shift_adv;
        // Leave the bit counter at zero on the way back to IDLE.
        bit_cnt <= bit_end ? '0 : bit_cnt + 1'b1;
      end else begin
        cyc_cnt <= cyc_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench: instance a is MSB-first, one clock per bit; instance b is
// LSB-first, three clocks per bit.
module tb_piso_serializer;

  logic clk = 1'b0;
  logic rst;

  logic [7:0] a_data;
  logic       a_valid, a_ready, a_out, a_sval, a_strobe, a_first, a_last, a_busy;
  logic [7:0] b_data;
  logic       b_valid, b_ready, b_out, b_sval, b_strobe, b_first, b_last, b_busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WORD_WIDTH(8), .BIT_CYCLES(1), .MSB_FIRST(1'b1)) dut_a (
    .clk(clk), .rst(rst), .in_data(a_data), .in_valid(a_valid), .in_ready(a_ready),
    .ser_out(a_out), .ser_valid(a_sval), .ser_strobe(a_strobe), .ser_first(a_first),
    .ser_last(a_last), .busy(a_busy)
  );

  piso_serializer #(.WORD_WIDTH(8), .BIT_CYCLES(3), .MSB_FIRST(1'b0)) dut_b (
    .clk(clk), .rst(rst), .in_data(b_data), .in_valid(b_valid), .in_ready(b_ready),
    .ser_out(b_out), .ser_valid(b_sval), .ser_strobe(b_strobe), .ser_first(b_first),
    .ser_last(b_last), .busy(b_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_a_idle(input string tag);
    chk({tag, ".a_flags"}, {26'd0, a_out, a_sval, a_strobe, a_first, a_last, a_busy}, 32'd0);
  endtask

  initial begin
    logic [7:0]  w;
    logic [15:0] stream;
    int          strobes;
    int          busy_cnt;

    // Reset with a valid word presented: nothing may be transferred.
    rst = 1'b1; a_valid = 1'b1; a_data = 8'hFF; b_valid = 1'b1; b_data = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_a_idle($sformatf("reset%0d", i));
      chk($sformatf("reset%0d.b_flags", i),
          {26'd0, b_out, b_sval, b_strobe, b_first, b_last, b_busy}, 32'd0);
    end
    rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk($sformatf("idle%0d.a_ready", i), a_ready, 1'b1);
      chk($sformatf("idle%0d.b_ready", i), b_ready, 1'b1);
      chk_a_idle($sformatf("idle%0d", i));
    end
    $display("reset/idle done");

    // Single word 0xA5 MSB-first.
    w = 8'hA5; a_data = w; a_valid = 1'b1;
    tick();
    a_valid = 1'b0; a_data = 8'h00;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("a5.bit%0d.out", i), a_out, w[7-i]);
      chk($sformatf("a5.bit%0d.flags", i), {28'd0, a_sval, a_strobe, a_first, a_last},
          {28'd0, 1'b1, 1'b1, (i == 0), (i == 7)});
      chk($sformatf("a5.bit%0d.ready", i), a_ready, (i == 7));
      tick();
    end
    chk_a_idle("a5.after");
    $display("word 0xA5 msb-first done");

    // Word 0x01 LSB-first, three clocks per bit.
    b_data = 8'h01; b_valid = 1'b1;
    tick();
    b_valid = 1'b0;
    strobes = 0; busy_cnt = 0;
    for (int i = 0; i < 24; i++) begin
      chk($sformatf("b01.clk%0d.out", i), b_out, (i < 3));
      chk($sformatf("b01.clk%0d.strobe", i), b_strobe, (i % 3 == 0));
      chk($sformatf("b01.clk%0d.first_last", i), {b_first, b_last}, {(i < 3), (i >= 21)});
      if (b_strobe) strobes++;
      if (b_busy) busy_cnt++;
      tick();
    end
    chk("b01.after.busy", b_busy, 1'b0);
    chk("b01.after.out", b_out, 1'b0);
    chk("b01.strobe_count", strobes, 8);
    chk("b01.busy_count", busy_cnt, 24);
    $display("word 0x01 lsb-first x3 done");

    // Back-to-back 0xF0 then 0x0F with in_valid held.
    stream = 16'hF00F;
    a_data = 8'hF0; a_valid = 1'b1;
    tick();
    a_data = 8'h0F;
    for (int i = 0; i < 16; i++) begin
      if (i == 8) a_valid = 1'b0;
      chk($sformatf("b2b.bit%0d.out", i), a_out, stream[15-i]);
      chk($sformatf("b2b.bit%0d.valid", i), a_sval, 1'b1);
      chk($sformatf("b2b.bit%0d.first", i), a_first, (i == 0 || i == 8));
      if (i < 15) chk($sformatf("b2b.bit%0d.ready", i), a_ready, (i == 7));
      tick();
    end
    chk_a_idle("b2b.after");
    $display("back-to-back 0xF0/0x0F done");

    // Backpressure: 0x3C offered mid-word, replaced by 0xC3 before in_ready.
    a_data = 8'h55; a_valid = 1'b1;
    tick();
    a_data = 8'h3C;
    for (int i = 0; i < 7; i++) begin
      if (i == 3) a_data = 8'hC3;
      chk($sformatf("bp.busy%0d.ready", i), a_ready, 1'b0);
      chk($sformatf("bp.busy%0d.out", i), a_out, (i % 2 == 1));
      tick();
    end
    chk("bp.last.ready", a_ready, 1'b1);
    tick();
    a_valid = 1'b0;
    w = 8'hC3;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("bp.c3.bit%0d.out", i), a_out, w[7-i]);
      chk($sformatf("bp.c3.bit%0d.first", i), a_first, (i == 0));
      tick();
    end
    chk_a_idle("bp.after");
    $display("backpressure 0xC3 done");

    // Reset in the middle of 0xAA aborts the word.
    a_data = 8'hAA; a_valid = 1'b1;
    tick();
    a_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("rmid.bit4.valid", a_sval, 1'b1);
    rst = 1'b1;
    tick();
    chk_a_idle("rmid.reset");
    rst = 1'b0;
    tick();
    chk_a_idle("rmid.idle");
    chk("rmid.idle.ready", a_ready, 1'b1);
    a_data = 8'h81; a_valid = 1'b1;
    tick();
    a_valid = 1'b0;
    chk("rmid.new.flags", {28'd0, a_out, a_sval, a_strobe, a_first}, 32'hF);
    tick();
    chk("rmid.new.bit1", {30'd0, a_out, a_first}, 32'd0);
    $display("reset mid-word done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
